ss_restore_reader: RTL and testbench
====================================

Name: ss_restore_reader

Overview:
- Save-state restore engine: the read-side counterpart of the save-state writer.
- Fetches a save-state image from DDR at SS_DDR_BASE + slot*SLOT_BYTES and parses its section headers.
- Streams each section's 64-bit payload words to the owning device, selected by SSIDX_* index, over a valid/ack write port.
- Sits between the DDR arbiter read channel and the per-device save-state ports (scn RAM, pri RAM, CPU RAM, scn regs, obj RAM, global).

Parameters:
- BURST, 8, max DDR burst length in 64-bit words (power of 2, 1..64).
- SLOT_BYTES, 32'h0002_0000, byte size of one save-state slot; image must not cross it.
- SLOTS, 4, number of slots; slot input width is $clog2(SLOTS).
- MAX_IDX, 5, highest legal section index (SSIDX_OBJ_RAM).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin restore; ignored while busy
- slot  in  $clog2(SLOTS)  slot number, sampled on start
- busy  out  1  high from cycle after accepted start until done/error
- done  out  1  one-cycle pulse, end marker reached cleanly
- error  out  1  one-cycle pulse, restore aborted
- err_code  out  2  1=bad magic, 2=bad index, 3=slot overrun; held until next start
- ddr_addr  out  32  byte address, 8-byte aligned
- ddr_burstcnt  out  8  words requested
- ddr_read  out  1  read request, held until !ddr_busy
- ddr_busy  in  1  arbiter stall
- ddr_rdata  in  64  read data
- ddr_rdata_ready  in  1  rdata valid, one word per cycle
- ss_idx  out  8  target section index
- ss_addr  out  24  word offset within section
- ss_data  out  64  payload word
- ss_write  out  1  word valid
- ss_ack  in  1  device accepted word this cycle

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, err_code 0.
- Header word layout:
  - [31:0] = SS_SECTION_MAGIC 32'h5353_4543
  - [55:32] = word count N
  - [63:56] = idx
  - idx 8'hFF is the end marker; its count is ignored.
- FSM states: IDLE, HDR_REQ, HDR_WAIT, DATA_REQ, STREAM, DONE, ERROR.
- IDLE -> HDR_REQ on start:
  - hdr_ptr = SS_DDR_BASE + slot*SLOT_BYTES
  - limit = hdr_ptr + SLOT_BYTES
  - err_code cleared
- HDR_REQ: assert ddr_read, addr = hdr_ptr, burstcnt = 1. Request accepted on the cycle ddr_read & !ddr_busy; go to HDR_WAIT.
- HDR_WAIT, on ddr_rdata_ready, check in this priority order:
  - magic mismatch -> ERROR (code 1)
  - idx == FF -> DONE
  - idx > MAX_IDX -> ERROR (code 2)
  - hdr_ptr + 8*(1+N) > limit -> ERROR (code 3)
  - N == 0 -> hdr_ptr += 8, back to HDR_REQ
  - otherwise latch idx/N, rd_ptr = hdr_ptr + 8, remaining = N, ss_addr = 0, go to DATA_REQ.
- DATA_REQ: request len = min(BURST, remaining) only when FIFO free >= len. On acceptance: rd_ptr += 8*len, remaining -= len, go to STREAM.
- STREAM:
  - Returned words are pushed into a FIFO of depth 2*BURST; overflow is impossible by construction.
  - ss_write = FIFO not empty; ss_data = FIFO head.
  - Pop and ss_addr++ on ss_write & ss_ack.
  - ss_data, ss_idx and ss_addr stay stable while ss_write is high and ss_ack is low.
  - Bursts may overlap streaming: when remaining > 0 and free >= the next len, re-issue from STREAM (no return to DATA_REQ needed).
  - Section ends when remaining == 0, no burst is outstanding and the FIFO is empty. Then hdr_ptr = rd_ptr and go to HDR_REQ.
- DONE / ERROR: pulse done or error for 1 cycle, set busy = 0, return to IDLE.
- Outstanding-burst tracking: count of expected words, decremented on ddr_rdata_ready. ddr_rdata_ready outside an expected window is ignored.
- In-flight burst on ERROR: an error can only occur in HDR_WAIT, with nothing else outstanding.
- Simultaneous push and pop in the same cycle: FIFO count is unchanged.
- Slot overrun is detected from header arithmetic before any payload is read. Use 33-bit compare; no wrap.
- Reset mid-operation: asynchronous return to reset state. Any DDR beats still in flight after reset are ignored.

Decomposition:
- Add to system_consts:
  - SS_SECTION_MAGIC
  - SS_IDX_END = 8'hFF
  - typedef ss_header_t, a packed struct {idx[7:0], count[23:0], magic[31:0]}
  - enum ss_err_t
- One sub-module: ss_rd_fifo, a synchronous FIFO.
  - Parameters: WIDTH=64, DEPTH=2*BURST.
  - Ports: push, pop, din, dout, count, empty.
  - Same clk/reset_n.

Test Plan:
- slot 1, one section {idx 3, N=20}, then end marker:
  - header read at 0x0002_0000
  - bursts 8, 8, 4 from 0x0002_0008
  - ss_addr 0..19, ss_idx 3
  - next header read at 0x0002_00A8; done pulse, busy 0.
- ss_ack held low 50 cycles mid-section: ss_data/ss_addr frozen; at most 16 words fetched ahead; no word lost or duplicated.
- Sections {1,N=0}, {5,N=1}, end: the N=0 section produces no ss_write; exactly one write with idx 5, addr 0; done.
- Magic 32'hDEAD_BEEF in the first header: error pulse, err_code 1, no ss_write, no further ddr_read.
- idx 6 -> err_code 2. Header with N=0x4000 in a 128 KiB slot -> err_code 3 with no payload read.
- reset_n asserted mid-STREAM with ddr_busy toggling: all outputs 0 immediately. A new start afterwards restores correctly; stray rdata_ready beats are ignored.

Source files
------------

// File: rtl/ss_restore_reader_pkg.sv
// Shared constants and types for the save-state restore path.
// Header layout, section index end marker and restore error codes.
package ss_restore_reader_pkg;

  localparam logic [31:0] SS_DDR_BASE      = 32'h0000_0000;
  localparam logic [31:0] SS_SECTION_MAGIC = 32'h5353_4543;
  localparam logic [7:0]  SS_IDX_END       = 8'hFF;

  typedef struct packed {
    logic [7:0]  idx;
    logic [23:0] count;
    logic [31:0] magic;
  } ss_header_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_MAGIC   = 2'd1,
    ERR_INDEX   = 2'd2,
    ERR_OVERRUN = 2'd3
  } ss_err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_REQ,
    S_HDR_WAIT,
    S_DATA_REQ,
    S_STREAM,
    S_DONE,
    S_ERROR
  } rd_state_t;

endpackage

// File: rtl/ss_rd_fifo.sv
// Payload staging FIFO between the DDR read channel and the device write port.
// DEPTH must be a power of two so the pointers wrap naturally.
module ss_rd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (32'(count) < DEPTH);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ss_restore_reader.sv
// Save-state restore engine: walks section headers of a DDR slot image and
// streams each section's payload words to the owning device.
//
// state      | meaning
// IDLE       | waiting for start
// HDR_REQ    | requesting one header word at hdr_ptr
// HDR_WAIT   | waiting for the header word, then validating it
// DATA_REQ   | issuing the first payload burst of a section
// STREAM     | draining the FIFO to the device, refilling with further bursts
// DONE       | end marker reached, one-cycle done pulse
// ERROR      | restore aborted, one-cycle error pulse
module ss_restore_reader
  import ss_restore_reader_pkg::*;
#(
  parameter int          BURST      = 8,
  parameter logic [31:0] SLOT_BYTES = 32'h0002_0000,
  parameter int          SLOTS      = 4,
  parameter int          MAX_IDX    = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [$clog2(SLOTS)-1:0] slot,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [31:0]              ddr_addr,
  output logic [7:0]               ddr_burstcnt,
  output logic                     ddr_read,
  input  logic                     ddr_busy,
  input  logic [63:0]              ddr_rdata,
  input  logic                     ddr_rdata_ready,
  output logic [7:0]               ss_idx,
  output logic [23:0]              ss_addr,
  output logic [63:0]              ss_data,
  output logic                     ss_write,
  input  logic                     ss_ack
);
  localparam int DEPTH = 2 * BURST;
  localparam int CW    = $clog2(DEPTH + 1);

  rd_state_t     state_q, state_d;
  logic [31:0]   hdr_ptr_q, hdr_ptr_d;
  logic [31:0]   rd_ptr_q, rd_ptr_d;
  logic [32:0]   limit_q, limit_d;
  logic [23:0]   remain_q, remain_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    idx_q, idx_d;
  logic [CW-1:0] outst_q, outst_d;
  ss_err_t       err_q, err_d;

  ss_header_t    hdr;
  logic [32:0]   hdr_end;
  logic [31:0]   slot_base;
  logic [7:0]    req_len;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] free_words;
  logic [63:0]   fifo_dout;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic          accept;

  assign hdr        = ss_header_t'(ddr_rdata);
  // 33-bit end address so a section reaching past 4 GiB cannot wrap under the limit
  assign hdr_end    = {1'b0, hdr_ptr_q} + ((33'(hdr.count) + 33'd1) << 3);
  assign slot_base  = SS_DDR_BASE + 32'(slot) * SLOT_BYTES;
  assign req_len    = (remain_q >= 24'(BURST)) ? 8'(BURST) : remain_q[7:0];
  // words already in flight are reserved so returned data always fits
  assign free_words = CW'(DEPTH) - fifo_count - outst_q;
  assign can_issue  = (remain_q != '0) && (32'(free_words) >= 32'(req_len));
  assign push       = ddr_rdata_ready && (outst_q != '0);

  assign ss_write = !fifo_empty;
  assign pop      = ss_write && ss_ack;
  assign ss_data  = ss_write ? fifo_dout : '0;
  assign ss_idx   = idx_q;
  assign ss_addr  = addr_q;
  assign err_code = err_q;
  assign busy     = state_q inside {S_HDR_REQ, S_HDR_WAIT, S_DATA_REQ, S_STREAM};
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERROR);

  ss_rd_fifo #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (ddr_rdata),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      hdr_ptr_q <= '0;
      rd_ptr_q  <= '0;
      limit_q   <= '0;
      remain_q  <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      outst_q   <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      hdr_ptr_q <= hdr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      limit_q   <= limit_d;
      remain_q  <= remain_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_ptr_d    = hdr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    limit_d      = limit_q;
    remain_d     = remain_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    err_d        = err_q;
    accept       = 1'b0;
    ddr_read     = 1'b0;
    ddr_addr     = '0;
    ddr_burstcnt = '0;

    if (pop) addr_d = addr_q + 24'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          hdr_ptr_d = slot_base;
          limit_d   = {1'b0, slot_base} + {1'b0, SLOT_BYTES};
          err_d     = ERR_NONE;
          state_d   = S_HDR_REQ;
        end
      end
      S_HDR_REQ: begin
        ddr_read     = 1'b1;
        ddr_addr     = hdr_ptr_q;
        ddr_burstcnt = 8'd1;
        if (!ddr_busy) state_d = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        if (ddr_rdata_ready) begin
          if (hdr.magic != SS_SECTION_MAGIC) begin
            err_d   = ERR_MAGIC;
            state_d = S_ERROR;
          end else if (hdr.idx == SS_IDX_END) begin
            state_d = S_DONE;
          end else if (32'(hdr.idx) > MAX_IDX) begin
            err_d   = ERR_INDEX;
            state_d = S_ERROR;
          end else if (hdr_end > limit_q) begin
            err_d   = ERR_OVERRUN;
            state_d = S_ERROR;
          end else if (hdr.count == '0) begin
            hdr_ptr_d = hdr_ptr_q + 32'd8;
            state_d   = S_HDR_REQ;
          end else begin
            idx_d    = hdr.idx;
            rd_ptr_d = hdr_ptr_q + 32'd8;
            remain_d = hdr.count;
            addr_d   = '0;
            state_d  = S_DATA_REQ;
          end
        end
      end
      S_DATA_REQ, S_STREAM: begin
        if (can_issue) begin
          ddr_read     = 1'b1;
          ddr_addr     = rd_ptr_q;
          ddr_burstcnt = req_len;
          if (!ddr_busy) begin
            accept   = 1'b1;
            rd_ptr_d = rd_ptr_q + {21'd0, req_len, 3'd0};
            remain_d = remain_q - {16'd0, req_len};
            state_d  = S_STREAM;
          end
        end else if (state_q == S_STREAM && remain_q == '0 && outst_q == '0 && fifo_empty) begin
          hdr_ptr_d = rd_ptr_q;
          state_d   = S_HDR_REQ;
        end
      end
      S_DONE, S_ERROR: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase

    outst_d = outst_q + (accept ? CW'(req_len) : CW'(0)) - (push ? CW'(1) : CW'(0));
  end

endmodule

// File: tb/tb_ss_restore_reader.sv
// Randomized bench for ss_restore_reader: DDR and device responders plus an
// image-walking reference model of the expected requests, writes and outcome.
module tb_ss_restore_reader;
  import ss_restore_reader_pkg::*;

  localparam longint SLOT_B = 64'h0002_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  slot = '0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_burstcnt;
  logic        ddr_read;
  logic        ddr_busy = 1'b0;
  logic [63:0] ddr_rdata = '0;
  logic        ddr_rdata_ready = 1'b0;
  logic [7:0]  ss_idx;
  logic [23:0] ss_addr;
  logic [63:0] ss_data;
  logic        ss_write;
  logic        ss_ack = 1'b0;

  always #5 clk = ~clk;

  ss_restore_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .slot(slot),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt), .ddr_read(ddr_read),
    .ddr_busy(ddr_busy), .ddr_rdata(ddr_rdata), .ddr_rdata_ready(ddr_rdata_ready),
    .ss_idx(ss_idx), .ss_addr(ss_addr), .ss_data(ss_data), .ss_write(ss_write),
    .ss_ack(ss_ack)
  );

  typedef struct { logic [31:0] addr; int len; bit hdr; } req_t;
  typedef struct { logic [7:0] idx; logic [23:0] addr; logic [63:0] data; } wr_t;

  logic [63:0] mem [logic [31:0]];
  req_t        exp_req[$];
  wr_t         exp_wr[$];
  wr_t         got_wr[$];
  logic [31:0] beat_q[$];
  int          exp_err;
  int          req_i, n_done, n_error, data_words, max_ahead, ack_hold;
  int          n_vec = 0, n_err = 0;
  int          busy_pct = 30, ack_pct = 70;
  bit          start_pend = 1'b0;
  bit          prev_wr = 1'b0, prev_ack = 1'b0;
  logic [63:0] prev_data;
  logic [23:0] prev_addr;
  logic [7:0]  prev_idx;
  logic [31:0] bptr;
  logic [1:0]  rs;
  int          nsec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  task automatic put_sec(input logic [7:0] idx, input logic [23:0] n, input logic [31:0] magic);
    mem[bptr] = {idx, n, magic};
    for (int k = 0; k < int'(n) && k < 64; k++)
      mem[bptr + 32'(8 * (k + 1))] = {$urandom, $urandom};
    bptr = bptr + 32'(8 * (int'(n) + 1));
  endtask

  // Walks the image by the header rules: one header read, then payload in bursts of up to 8.
  task automatic build_expect(input logic [1:0] s);
    longint p, lim, n, len;
    logic [63:0] h;
    exp_req.delete();
    exp_wr.delete();
    p = longint'(s) * SLOT_B;
    lim = p + SLOT_B;
    exp_err = -1;
    for (int sec = 0; sec < 32 && exp_err < 0; sec++) begin
      h = mem_rd(32'(p));
      exp_req.push_back('{32'(p), 1, 1'b1});
      if (h[31:0] != SS_SECTION_MAGIC) exp_err = 1;
      else if (h[63:56] == 8'hFF) exp_err = 0;
      else if (h[63:56] > 8'd5) exp_err = 2;
      else begin
        n = longint'(h[55:32]);
        if (p + 8 * (n + 1) > lim) exp_err = 3;
        else begin
          for (longint k = 0; k < n; k++)
            exp_wr.push_back('{h[63:56], 24'(k), mem_rd(32'(p + 8 + 8 * k))});
          for (longint off = 0; off < n; off += 8) begin
            len = (n - off < 8) ? n - off : 8;
            exp_req.push_back('{32'(p + 8 + 8 * off), int'(len), 1'b0});
          end
          p = p + 8 * (n + 1);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    start = start_pend;
    start_pend = 1'b0;
    ddr_busy = ($urandom_range(0, 99) < busy_pct);
    if (ack_hold > 0) begin
      ss_ack = 1'b0;
      ack_hold--;
    end else ss_ack = ($urandom_range(0, 99) < ack_pct);
    if (beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      ddr_rdata_ready = 1'b1;
      ddr_rdata = mem_rd(beat_q.pop_front());
    end else begin
      ddr_rdata_ready = 1'b0;
      ddr_rdata = {$urandom, $urandom};
    end
    #1;
    if (prev_wr && !prev_ack) begin
      check("hold_write", ss_write, 1);
      check("hold_data", ss_data, prev_data);
      check("hold_addr", ss_addr, prev_addr);
      check("hold_idx", ss_idx, prev_idx);
    end
    prev_wr = ss_write; prev_ack = ss_ack;
    prev_data = ss_data; prev_addr = ss_addr; prev_idx = ss_idx;
    if (ddr_read && !ddr_busy) begin
      if (req_i < exp_req.size()) begin
        check("req_addr", ddr_addr, exp_req[req_i].addr);
        check("req_len", ddr_burstcnt, exp_req[req_i].len);
        if (!exp_req[req_i].hdr) data_words += int'(ddr_burstcnt);
      end
      req_i++;
      for (int k = 0; k < int'(ddr_burstcnt); k++) beat_q.push_back(ddr_addr + 32'(8 * k));
    end
    if (ss_write && ss_ack) got_wr.push_back('{ss_idx, ss_addr, ss_data});
    if (data_words - got_wr.size() > max_ahead) max_ahead = data_words - got_wr.size();
    if (done) n_done++;
    if (error) n_error++;
  endtask

  task automatic run_start(input logic [1:0] s);
    build_expect(s);
    req_i = 0; n_done = 0; n_error = 0; data_words = 0; max_ahead = 0; ack_hold = 0;
    got_wr.delete();
    beat_q.delete();
    slot = s;
    start_pend = 1'b1;
    step();
    step();
    check("busy_start", busy, 1);
  endtask

  task automatic run_finish(input bit stall);
    bit stalled = 1'b0;
    int cyc = 0;
    while (n_done == 0 && n_error == 0 && cyc < 4000) begin
      if (stall && !stalled && got_wr.size() >= 5) begin
        stalled = 1'b1;
        ack_hold = 50;
      end
      step();
      cyc++;
    end
    check("timeout", cyc < 4000, 1);
    repeat (8) step();
    check("done_pulses", n_done, exp_err == 0);
    check("err_pulses", n_error, exp_err > 0);
    check("err_code", err_code, exp_err);
    check("busy_end", busy, 0);
    check("req_count", req_i, exp_req.size());
    check("wr_count", got_wr.size(), exp_wr.size());
    for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++) begin
      check("wr_data", got_wr[k].data, exp_wr[k].data);
      check("wr_idx_addr", {got_wr[k].idx, got_wr[k].addr}, {exp_wr[k].idx, exp_wr[k].addr});
    end
    if (stall) check("ahead_max", max_ahead <= 16, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_ctrl", {busy, done, error, err_code, ddr_read, ss_write}, 0);
    check("rst_ddr", {ddr_addr, ddr_burstcnt}, 0);
    check("rst_ss", {ss_idx, ss_addr}, 0);
    check("rst_ss_data", ss_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // one section of 20 words in slot 1
    mem.delete(); bptr = 32'h0002_0000;
    put_sec(8'd3, 24'd20, SS_SECTION_MAGIC);
    put_sec(8'hFF, 24'd0, SS_SECTION_MAGIC);
    run_start(2'd1); run_finish(1'b0);

    // device stalls 50 cycles mid-section
    mem.delete(); bptr = 32'h0004_0000;
    put_sec(8'd2, 24'd40, SS_SECTION_MAGIC);
    put_sec(8'hFF, 24'd0, SS_SECTION_MAGIC);
    run_start(2'd2); run_finish(1'b1);

    // empty section then a single-word section
    mem.delete(); bptr = 32'h0000_0000;
    put_sec(8'd1, 24'd0, SS_SECTION_MAGIC);
    put_sec(8'd5, 24'd1, SS_SECTION_MAGIC);
    put_sec(8'hFF, 24'd7, SS_SECTION_MAGIC);
    run_start(2'd0); run_finish(1'b0);

    mem.delete(); bptr = 32'h0006_0000;
    put_sec(8'd0, 24'd4, 32'hDEAD_BEEF);
    run_start(2'd3); run_finish(1'b0);

    mem.delete(); bptr = 32'h0000_0000;
    put_sec(8'd4, 24'd3, SS_SECTION_MAGIC);
    put_sec(8'd6, 24'd2, SS_SECTION_MAGIC);
    run_start(2'd0); run_finish(1'b0);

    mem.delete(); bptr = 32'h0002_0000;
    put_sec(8'd2, 24'h4000, SS_SECTION_MAGIC);
    run_start(2'd1); run_finish(1'b0);

    for (int r = 0; r < 8; r++) begin
      rs = 2'($urandom_range(0, 3));
      mem.delete();
      bptr = 32'(longint'(rs) * SLOT_B);
      nsec = $urandom_range(1, 4);
      for (int i = 0; i < nsec; i++)
        put_sec(8'($urandom_range(0, 5)), 24'($urandom_range(0, 25)), SS_SECTION_MAGIC);
      case ($urandom_range(0, 5))
        0:       put_sec(8'd1, 24'd2, 32'hDEAD_BEEF);
        1:       put_sec(8'($urandom_range(6, 254)), 24'd1, SS_SECTION_MAGIC);
        2:       put_sec(8'd0, 24'h4000, SS_SECTION_MAGIC);
        default: put_sec(8'hFF, 24'($urandom), SS_SECTION_MAGIC);
      endcase
      run_start(rs); run_finish(r == 3);
    end

    // reset mid-stream with the arbiter stalling often
    mem.delete(); bptr = 32'h0004_0000;
    put_sec(8'd3, 24'd60, SS_SECTION_MAGIC);
    put_sec(8'hFF, 24'd0, SS_SECTION_MAGIC);
    busy_pct = 50;
    run_start(2'd2);
    for (int c = 0; c < 2000 && got_wr.size() < 10; c++) step();
    check("pre_reset_progress", got_wr.size() >= 10, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {busy, done, error, err_code, ddr_read, ss_write}, 0);
    check("mid_rst_ddr", {ddr_addr, ddr_burstcnt}, 0);
    check("mid_rst_ss", {ss_idx, ss_addr}, 0);
    check("mid_rst_ss_data", ss_data, 0);
    prev_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    beat_q.push_back(32'h0004_0008);
    beat_q.push_back(32'h0004_0000);
    beat_q.push_back(32'h0004_0010);
    for (int c = 0; c < 200 && beat_q.size() > 0; c++) step();
    check("stray_idle", {busy, ddr_read, ss_write, error}, 0);
    busy_pct = 30;
    run_start(2'd2); run_finish(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
